// File: rtl/sd_block_checker.sv
// Checks one SD sector read against the (seed + index) byte pattern and reports results.
// Optional SD_CHK_SUM_EN adds sum_o, a 16-bit wrapping sum of all compared bytes.
module sd_block_checker #(
  parameter int unsigned BLOCK_BYTES    = 512,
  parameter int unsigned IDX_W          = 10,
  parameter int unsigned ERR_W          = 10,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic             SD_clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       seed_i,
  input  logic [7:0]       data_i,
  input  logic             valid_i,
  input  logic             read_o,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic             timeout,
  output logic             overrun,
  output logic [ERR_W-1:0] err_cnt,
  output logic [IDX_W-1:0] byte_cnt,
  output logic [IDX_W-1:0] first_err_idx,
`ifdef SD_CHK_SUM_EN
  output logic [15:0]      sum_o,
`endif
  output logic [7:0]       first_err_data
);

  localparam int unsigned TimerW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [IDX_W-1:0]  BlockCnt = IDX_W'(BLOCK_BYTES);
  localparam logic [TimerW-1:0] TmoCnt   = TimerW'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StIdle, StArmed, StRecv, StFull, StDone} state_e;

  state_e            state_q, state_d;
  logic [7:0]        seed_q, seed_d;
  logic [IDX_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [ERR_W-1:0]  err_cnt_q, err_cnt_d;
  logic [IDX_W-1:0]  first_idx_q, first_idx_d;
  logic [7:0]        first_data_q, first_data_d;
  logic              pass_q, pass_d;
  logic              timeout_q, timeout_d;
  logic              overrun_q, overrun_d;
  logic [TimerW-1:0] timer_q, timer_d;
  logic [7:0]        exp_byte;
`ifdef SD_CHK_SUM_EN
  logic [15:0]       sum_q, sum_d;
`endif

  assign exp_byte = seed_q + 8'(byte_cnt_q);

  always_comb begin
    state_d      = state_q;
    seed_d       = seed_q;
    byte_cnt_d   = byte_cnt_q;
    err_cnt_d    = err_cnt_q;
    first_idx_d  = first_idx_q;
    first_data_d = first_data_q;
    pass_d       = pass_q;
    timeout_d    = timeout_q;
    overrun_d    = overrun_q;
    timer_d      = timer_q;
`ifdef SD_CHK_SUM_EN
    sum_d        = sum_q;
`endif
    unique case (state_q)
      StIdle: begin
        if (start) begin
          state_d      = StArmed;
          seed_d       = seed_i;
          byte_cnt_d   = '0;
          err_cnt_d    = '0;
          first_idx_d  = '0;
          first_data_d = '0;
          pass_d       = 1'b0;
          timeout_d    = 1'b0;
          overrun_d    = 1'b0;
          timer_d      = '0;
`ifdef SD_CHK_SUM_EN
          sum_d        = '0;
`endif
        end
      end
      StArmed, StRecv: begin
        if (valid_i) begin
          if (data_i != exp_byte) begin
            if (err_cnt_q != '1) err_cnt_d = err_cnt_q + ERR_W'(1);
            if (err_cnt_q == '0) begin
              first_idx_d  = byte_cnt_q;
              first_data_d = data_i;
            end
          end
`ifdef SD_CHK_SUM_EN
          sum_d      = sum_q + 16'(data_i);
`endif
          byte_cnt_d = byte_cnt_q + IDX_W'(1);
          timer_d    = '0;
          state_d    = (byte_cnt_d == BlockCnt) ? StFull : StRecv;
        end else begin
          timer_d = timer_q + TimerW'(1);
          if (timer_d == TmoCnt) begin
            timeout_d = 1'b1;
            state_d   = StDone;
          end
        end
        // read_o is judged against the count that already includes this cycle's byte
        if (read_o) state_d = StDone;
      end
      StFull: begin
        if (valid_i) overrun_d = 1'b1;
        if (read_o) state_d = StDone;
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    if (state_d == StDone && state_q != StDone) begin
      pass_d = (byte_cnt_d == BlockCnt) && (err_cnt_d == '0) && !overrun_d && !timeout_d;
    end
  end

  always_ff @(posedge SD_clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      seed_q       <= '0;
      byte_cnt_q   <= '0;
      err_cnt_q    <= '0;
      first_idx_q  <= '0;
      first_data_q <= '0;
      pass_q       <= 1'b0;
      timeout_q    <= 1'b0;
      overrun_q    <= 1'b0;
      timer_q      <= '0;
`ifdef SD_CHK_SUM_EN
      sum_q        <= '0;
`endif
    end else begin
      state_q      <= state_d;
      seed_q       <= seed_d;
      byte_cnt_q   <= byte_cnt_d;
      err_cnt_q    <= err_cnt_d;
      first_idx_q  <= first_idx_d;
      first_data_q <= first_data_d;
      pass_q       <= pass_d;
      timeout_q    <= timeout_d;
      overrun_q    <= overrun_d;
      timer_q      <= timer_d;
`ifdef SD_CHK_SUM_EN
      sum_q        <= sum_d;
`endif
    end
  end

  assign busy           = (state_q == StArmed) || (state_q == StRecv) || (state_q == StFull);
  assign done           = (state_q == StDone);
  assign pass           = pass_q;
  assign timeout        = timeout_q;
  assign overrun        = overrun_q;
  assign err_cnt        = err_cnt_q;
  assign byte_cnt       = byte_cnt_q;
  assign first_err_idx  = first_idx_q;
  assign first_err_data = first_data_q;
`ifdef SD_CHK_SUM_EN
  assign sum_o          = sum_q;
`endif

endmodule

// File: tb/tb_sd_block_checker.sv
// Randomised self-checking bench for sd_block_checker against a sector-level reference model.
module tb_sd_block_checker;

  localparam int unsigned BB  = 512;
  localparam int unsigned IW  = 10;
  localparam int unsigned EW  = 8;
  localparam int unsigned TMO = 100;

  logic          SD_clk, rst_n, start, valid_i, read_o;
  logic [7:0]    seed_i, data_i;
  logic          busy, done, pass, timeout, overrun;
  logic [EW-1:0] err_cnt;
  logic [IW-1:0] byte_cnt, first_err_idx;
  logic [7:0]    first_err_data;
`ifdef SD_CHK_SUM_EN
  logic [15:0]   sum_o;
`endif

  int vectors = 0;
  int miscompares = 0;

  logic [7:0]  blk [$];
  int          exp_cnt, exp_err, exp_fidx;
  logic [7:0]  exp_fdata;
  logic [15:0] exp_sum;
  bit          exp_ovr, exp_pass;

  sd_block_checker #(
    .BLOCK_BYTES(BB), .IDX_W(IW), .ERR_W(EW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .SD_clk(SD_clk), .rst_n(rst_n), .start(start), .seed_i(seed_i), .data_i(data_i),
    .valid_i(valid_i), .read_o(read_o), .busy(busy), .done(done), .pass(pass),
    .timeout(timeout), .overrun(overrun), .err_cnt(err_cnt), .byte_cnt(byte_cnt),
    .first_err_idx(first_err_idx),
`ifdef SD_CHK_SUM_EN
    .sum_o(sum_o),
`endif
    .first_err_data(first_err_data)
  );

  initial SD_clk = 1'b0;
  always #5 SD_clk = ~SD_clk;

  task automatic step();
    @(posedge SD_clk);
    #1;
  endtask

  task automatic fill_pattern(input logic [7:0] sd, input int n);
    blk.delete();
    for (int i = 0; i < n; i++) blk.push_back(8'((int'(sd) + i) % 256));
  endtask

  // Sector-level expectation: first BB bytes compared, the rest only flag overrun.
  task automatic model(input logic [7:0] sd);
    int n = blk.size();
    int errs = 0;
    exp_fidx = 0; exp_fdata = 8'h00; exp_sum = 16'h0000;
    exp_cnt = (n > int'(BB)) ? int'(BB) : n;
    for (int i = 0; i < exp_cnt; i++) begin
      exp_sum = exp_sum + 16'(blk[i]);
      if (blk[i] != 8'((int'(sd) + i) % 256)) begin
        if (errs == 0) begin exp_fidx = i; exp_fdata = blk[i]; end
        errs++;
      end
    end
    exp_err  = (errs > 255) ? 255 : errs;
    exp_ovr  = (n > int'(BB));
    exp_pass = (n == int'(BB)) && (errs == 0);
  endtask

  // Arms, streams blk with random gaps, then strobes read_o; returns in the DONE cycle.
  task automatic run_block(input logic [7:0] sd, input bit coincident, input bit do_read,
                           input int maxgap);
    seed_i = sd; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < blk.size(); i++) begin
      repeat ($urandom_range(maxgap, 0)) begin
        seed_i = 8'($urandom); start = ($urandom % 4 == 0);
        step();
      end
      valid_i = 1'b1; data_i = blk[i];
      read_o  = coincident && (i == blk.size() - 1);
      seed_i  = 8'($urandom); start = ($urandom % 4 == 0);
      step();
      valid_i = 1'b0; read_o = 1'b0; start = 1'b0; data_i = 8'($urandom);
    end
    if (do_read && !(coincident && blk.size() > 0)) begin
      repeat ($urandom_range(maxgap, 0)) step();
      read_o = 1'b1;
      step();
      read_o = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 0; valid_i = 0; read_o = 0; seed_i = 0; data_i = 0;
    #12;
    vectors++;
    if ({busy, done, pass, timeout, overrun, err_cnt, byte_cnt, first_err_idx,
         first_err_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got busy=%b cnt=%0d err=%0d pass=%b, want all 0",
               busy, byte_cnt, err_cnt, pass);
    end
    @(negedge SD_clk); rst_n = 1'b1;
    step();
  endtask

  task automatic test_good_block();
    fill_pattern(8'h00, 512);
    run_block(8'h00, 1'b0, 1'b1, 2);
    vectors++;
    if ({done, pass, busy} !== 3'b110) begin
      miscompares++; $display("FAIL good_flags: done/pass/busy=%b%b%b want 110", done, pass, busy);
    end
    vectors++;
    if ({err_cnt, byte_cnt, first_err_idx} !== {8'd0, 10'd512, 10'd0}) begin
      miscompares++;
      $display("FAIL good_counts: err=%0d cnt=%0d idx=%0d want 0/512/0",
               err_cnt, byte_cnt, first_err_idx);
    end
`ifdef SD_CHK_SUM_EN
    vectors++;
    if (sum_o !== 16'hFF00) begin
      miscompares++; $display("FAIL good_sum: got %h want ff00", sum_o);
    end
`endif
    step();
    vectors++;
    if ({done, pass, busy} !== 3'b010) begin
      miscompares++;
      $display("FAIL good_hold: done/pass/busy=%b%b%b want 010", done, pass, busy);
    end
  endtask

  task automatic test_corrupt();
    fill_pattern(8'h10, 512);
    blk[300] = 8'hAA;
    run_block(8'h10, 1'b0, 1'b1, 1);
    vectors++;
    if ({done, pass, err_cnt, first_err_idx, first_err_data} !==
        {1'b1, 1'b0, 8'd1, 10'd300, 8'hAA}) begin
      miscompares++;
      $display("FAIL corrupt: pass=%b err=%0d idx=%0d data=%h want 0/1/300/aa",
               pass, err_cnt, first_err_idx, first_err_data);
    end
    step();
  endtask

  task automatic test_short();
    fill_pattern(8'h33, 400);
    run_block(8'h33, 1'b0, 1'b1, 1);
    vectors++;
    if ({done, pass, timeout, overrun, byte_cnt} !== {4'b1000, 10'd400}) begin
      miscompares++;
      $display("FAIL short: done=%b pass=%b to=%b ov=%b cnt=%0d want 1/0/0/0/400",
               done, pass, timeout, overrun, byte_cnt);
    end
    step();
  endtask

  task automatic test_overrun();
    fill_pattern(8'h00, 515);
    run_block(8'h00, 1'b0, 1'b1, 1);
    vectors++;
    if ({done, pass, overrun, byte_cnt, err_cnt} !== {3'b101, 10'd512, 8'd0}) begin
      miscompares++;
      $display("FAIL overrun: pass=%b ov=%b cnt=%0d err=%0d want 0/1/512/0",
               pass, overrun, byte_cnt, err_cnt);
    end
    step();
  endtask

  task automatic test_coincident();
    fill_pattern(8'hC7, 512);
    run_block(8'hC7, 1'b1, 1'b1, 1);
    vectors++;
    if ({done, pass, overrun, byte_cnt} !== {3'b110, 10'd512}) begin
      miscompares++;
      $display("FAIL coincident: done=%b pass=%b ov=%b cnt=%0d want 1/1/0/512",
               done, pass, overrun, byte_cnt);
    end
    step();
  endtask

  task automatic test_timeout();
    int cyc = 0;
    fill_pattern(8'h42, 10);
    run_block(8'h42, 1'b0, 1'b0, 0);
    while (!done && cyc < 300) begin
      step();
      cyc++;
    end
    vectors++;
    if (cyc !== 100) begin
      miscompares++; $display("FAIL timeout_latency: got %0d cycles want 100", cyc);
    end
    vectors++;
    if ({done, timeout, pass, byte_cnt} !== {3'b110, 10'd10}) begin
      miscompares++;
      $display("FAIL timeout_flags: done=%b to=%b pass=%b cnt=%0d want 1/1/0/10",
               done, timeout, pass, byte_cnt);
    end
    step();
    vectors++;
    if ({done, busy, timeout} !== 3'b001) begin
      miscompares++;
      $display("FAIL timeout_hold: done=%b busy=%b to=%b want 0/0/1", done, busy, timeout);
    end
  endtask

  task automatic test_saturate();
    fill_pattern(8'h55, 512);
    for (int i = 0; i < 512; i++) blk[i] = ~blk[i];
    run_block(8'h55, 1'b0, 1'b1, 0);
    vectors++;
    if ({pass, err_cnt, first_err_idx, first_err_data} !== {1'b0, 8'd255, 10'd0, 8'hAA}) begin
      miscompares++;
      $display("FAIL saturate: pass=%b err=%0d idx=%0d data=%h want 0/255/0/aa",
               pass, err_cnt, first_err_idx, first_err_data);
    end
    step();
  endtask

  task automatic test_start_in_done();
    fill_pattern(8'h01, 512);
    run_block(8'h01, 1'b0, 1'b1, 0);
    start = 1'b1; seed_i = 8'h77;
    step();
    start = 1'b0;
    vectors++;
    if ({busy, done, pass, byte_cnt} !== {3'b001, 10'd512}) begin
      miscompares++;
      $display("FAIL start_in_done: busy=%b done=%b pass=%b cnt=%0d want 0/0/1/512",
               busy, done, pass, byte_cnt);
    end
  endtask

  task automatic test_midreset();
    fill_pattern(8'h20, 200);
    blk[5] = 8'h00;
    seed_i = 8'h20; start = 1'b1;
    step();
    start = 1'b0;
    for (int i = 0; i < 200; i++) begin
      valid_i = 1'b1; data_i = blk[i];
      step();
    end
    valid_i = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, pass, timeout, overrun, err_cnt, byte_cnt, first_err_idx,
         first_err_data} !== '0) begin
      miscompares++;
      $display("FAIL midreset: busy=%b cnt=%0d err=%0d idx=%0d want all 0",
               busy, byte_cnt, err_cnt, first_err_idx);
    end
    @(negedge SD_clk); rst_n = 1'b1;
    step();
    fill_pattern(8'h20, 512);
    run_block(8'h20, 1'b0, 1'b1, 1);
    vectors++;
    if ({done, pass, err_cnt, byte_cnt} !== {2'b11, 8'd0, 10'd512}) begin
      miscompares++;
      $display("FAIL midreset_after: done=%b pass=%b err=%0d cnt=%0d want 1/1/0/512",
               done, pass, err_cnt, byte_cnt);
    end
    step();
  endtask

  task automatic test_random();
    for (int it = 0; it < 20; it++) begin
      logic [7:0] sd;
      int kind, n;
      bit coin;
      sd   = 8'($urandom);
      kind = int'($urandom % 5);
      case (kind)
        0, 1:    n = 512;
        2:       n = int'($urandom_range(511, 0));
        3:       n = int'($urandom_range(520, 513));
        default: n = 512;
      endcase
      fill_pattern(sd, n);
      if (kind == 1 || (n > 0 && $urandom % 3 == 0)) begin
        repeat ($urandom_range(4, 1)) begin
          int k = int'($urandom_range(n - 1, 0));
          blk[k] = blk[k] ^ 8'($urandom_range(255, 1));
        end
      end
      coin = (kind == 4) || ($urandom % 4 == 0);
      model(sd);
      run_block(sd, coin, 1'b1, 2);
      vectors++;
      if ({done, busy, pass, overrun, timeout} !== {2'b10, exp_pass, exp_ovr, 1'b0}) begin
        miscompares++;
        $display("FAIL rand%0d_flags: done=%b busy=%b pass=%b ov=%b to=%b want 1/0/%b/%b/0",
                 it, done, busy, pass, overrun, timeout, exp_pass, exp_ovr);
      end
      vectors++;
      if (byte_cnt !== IW'(exp_cnt) || err_cnt !== EW'(exp_err) ||
          first_err_idx !== IW'(exp_fidx) || first_err_data !== exp_fdata) begin
        miscompares++;
        $display("FAIL rand%0d_counts: cnt=%0d err=%0d idx=%0d data=%h want %0d/%0d/%0d/%h",
                 it, byte_cnt, err_cnt, first_err_idx, first_err_data,
                 exp_cnt, exp_err, exp_fidx, exp_fdata);
      end
`ifdef SD_CHK_SUM_EN
      vectors++;
      if (sum_o !== exp_sum) begin
        miscompares++; $display("FAIL rand%0d_sum: got %h want %h", it, sum_o, exp_sum);
      end
`endif
      step();
    end
  endtask

  initial begin
    test_reset();
    test_good_block();
    test_corrupt();
    test_short();
    test_overrun();
    test_coincident();
    test_timeout();
    test_saturate();
    test_start_in_done();
    test_midreset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/sd_block_checker.md
Name: sd_block_checker

Overview:
Downstream consumer of the SD block-read stage's byte stream (data/valid plus block-done strobe), clocked on SD_clk.
Compares each received byte of one 512-byte sector against the write stage's expected pattern: byte[i] = (seed + i) mod 256, i.e. 0..255,0..255 for seed 0.
Reports pass/fail, error count and first-mismatch details for board bring-up and debug probes.

Parameters:
BLOCK_BYTES, 512, bytes expected per sector read (power of two, 16..4096)
IDX_W, 10, width of byte counter; must satisfy 2^IDX_W > BLOCK_BYTES
ERR_W, 10, width of error counter (saturating)
TIMEOUT_CYCLES, 65535, SD_clk cycles allowed between consecutive bytes (and from arm to first byte) before abort

Ports:
SD_clk  in  1  block clock (SD clock domain)
rst_n  in  1  asynchronous active-low reset
start  in  1  one-cycle arm pulse; sampled only in IDLE
seed_i  in  8  pattern seed, latched on accepted start
data_i  in  8  read byte from SD read stage
valid_i  in  1  data_i qualifier, one cycle per byte
read_o  in  1  block-read-complete strobe from SD read stage
busy  out  1  high in ARMED/RECV/FULL
done  out  1  one-cycle pulse on entry to DONE
pass  out  1  result, valid from done until next accepted start
timeout  out  1  result flag: inter-byte timeout occurred
overrun  out  1  result flag: more than BLOCK_BYTES bytes received
err_cnt  out  ERR_W  mismatching-byte count, saturates at all-ones
byte_cnt  out  IDX_W  bytes received this run (saturates at BLOCK_BYTES)
first_err_idx  out  IDX_W  index of first mismatch (0 if none)
first_err_data  out  8  received value at first mismatch (0 if none)

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; internal timer 0.
- States: IDLE, ARMED, RECV, FULL, DONE; registered, single always block on SD_clk.
- IDLE: start=1 -> ARMED; clear err_cnt, byte_cnt, first_err_*, pass, timeout, overrun, timer; latch seed_i. Other inputs ignored.
- ARMED: first valid_i -> RECV (byte processed same cycle). read_o before any byte -> DONE, pass=0.
- Byte processing (ARMED/RECV, valid_i=1): expected = seed + byte_cnt[7:0] (8-bit wrap); mismatch -> err_cnt+1 (saturating); if first mismatch, capture first_err_idx=byte_cnt, first_err_data=data_i; byte_cnt+1; timer cleared.
- RECV: byte_cnt reaching BLOCK_BYTES (after the increment) -> FULL. read_o while byte_cnt<BLOCK_BYTES -> DONE, pass=0 (short block).
- FULL: further valid_i sets overrun=1 (sticky), byte not compared, counters unchanged; read_o -> DONE.
- Simultaneous valid_i and read_o: byte processed first; read_o then evaluated against the updated byte_cnt; the 512th byte arriving with read_o completes normally.
- Timer: counts every ARMED/RECV cycle without valid_i; reaching TIMEOUT_CYCLES -> timeout=1, DONE, pass=0. Timer not running in FULL.
- Entry to DONE: pass = (byte_cnt==BLOCK_BYTES) & (err_cnt==0) & !overrun & !timeout; done=1 for exactly one cycle. Next cycle -> IDLE; results held.
- start while busy or in DONE: ignored.
- Latency: done asserts the cycle after read_o (or the timeout cycle) is sampled.
- Mid-operation reset: immediate return to IDLE, all outputs 0; no partial result retained.

Optional Feature:
SD_CHK_SUM_EN: when defined, adds output sum_o[15:0], a 16-bit wrapping sum of all compared bytes (overrun bytes excluded); cleared on accepted start and reset; held after done. Expected for seed 0, 512 bytes: 16'hFF00. When undefined, port and logic are absent; all other behaviour is identical.

Test Plan:
- start, seed 0, 512 bytes 0..255,0..255 then read_o -> done 1 cycle, pass=1, err_cnt=0, byte_cnt=512, first_err_idx=0 (sum_o=16'hFF00 if enabled).
- seed 8'h10, byte 300 corrupted to 8'hAA -> pass=0, err_cnt=1, first_err_idx=300, first_err_data=8'hAA.
- 400 good bytes then read_o -> pass=0, byte_cnt=400, timeout=0, overrun=0.
- 515 bytes then read_o -> overrun=1, byte_cnt=512, pass=0; 512th byte coincident with read_o -> pass=1.
- TIMEOUT_CYCLES=100, start, 10 bytes, then idle -> timeout=1 exactly 100 cycles after last byte, done pulse, pass=0.
- rst_n low mid-RECV at byte 200 -> all outputs 0 asynchronously; following start plus good block -> pass=1.
